dsm_cic_decimator: RTL and testbench



---
 rtl/dsm_cic_decimator.sv | 77 +++++++
 tb/tb_dsm_cic_decimator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC (sinc^3) decimator by R = 2^LOG2_R. It rebuilds the multi-bit value
// carried by a delta-sigma modulator bitstream or by a MASH output word.
module dsm_cic_decimator #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned LOG2_R = 6,
    localparam int unsigned OUT_W = IN_W + 3 * LOG2_R
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    localparam int unsigned       EXT_W      = OUT_W - IN_W;
    localparam logic [LOG2_R-1:0] PHASE_LAST = '1;

    logic [OUT_W-1:0]  i1, i2, i3;
    logic [OUT_W-1:0]  d1, d2, d3;
    logic [LOG2_R-1:0] phase;

    logic [OUT_W-1:0]  x_ext;
    logic [OUT_W-1:0]  i1_nxt, i2_nxt, i3_nxt;
    logic [OUT_W-1:0]  c0, c1, c2, c3;
    logic              strobe;

    // Integrator updates and the comb chain. Integrators wrap modulo 2^OUT_W, and the
    // differencing in the comb undoes that wrap. The comb taps the updated i3, so the
    // chain has a total latency of z^-2 at the input rate.
    always_comb begin
        x_ext  = {{EXT_W{in_data[IN_W-1]}}, in_data};
        i1_nxt = i1 + x_ext;
        i2_nxt = i2 + i1;
        i3_nxt = i3 + i2;
        strobe = in_valid && (phase == PHASE_LAST);
        c0     = i3_nxt;
        c1     = c0 - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
    end

    // Integrators and the phase counter advance only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1    <= '0;
            i2    <= '0;
            i3    <= '0;
            phase <= '0;
        end else if (in_valid) begin
            i1    <= i1_nxt;
            i2    <= i2_nxt;
            i3    <= i3_nxt;
            phase <= phase + LOG2_R'(1);
        end
    end

    // Comb delays and the output register run at the decimated rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= strobe;
            if (strobe) begin
                d1       <= c0;
                d2       <= c1;
                d3       <= c2;
                out_data <= c3;
            end
        end
    end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator (R = 64). It checks reset, DC response,
// full-scale range, valid gaps and wrap-around against hand values and a convolution model.
module tb_dsm_cic_decimator;

    localparam int unsigned IN_W   = 4;
    localparam int unsigned LOG2_R = 6;
    localparam int unsigned OUT_W  = IN_W + 3 * LOG2_R;
    localparam int          R      = 64;
    localparam int          HLEN   = 3 * R - 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;

    int     n_cmp;
    int     n_bad;
    int     cyc;
    int     base;
    longint stim_x[$];
    bit     stim_v[$];
    longint out_q[$];
    int     cyc_q[$];
    longint h[HLEN];

    dsm_cic_decimator #(.IN_W(IN_W), .LOG2_R(LOG2_R)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse together with the edge count that produced it.
    always @(negedge clk) begin
        if (out_valid) begin
            out_q.push_back(longint'($signed(out_data)));
            cyc_q.push_back(cyc);
        end
    end

    // sinc^3 impulse response, built from three boxcars of length R.
    task build_h;
        longint h2[2*R-1];
        for (int k = 0; k < 2 * R - 1; k++) begin
            h2[k] = 0;
            for (int a = 0; a < R; a++)
                if (k - a >= 0 && k - a < R) h2[k] = h2[k] + 1;
        end
        for (int k = 0; k < HLEN; k++) begin
            h[k] = 0;
            for (int j = 0; j < R; j++)
                if (k - j >= 0 && k - j < 2 * R - 1) h[k] = h[k] + h2[k-j];
        end
    endtask

    // Expected m-th output (0-based). acc holds the accepted samples in order.
    function automatic longint ref_out(input longint acc[$], input int m);
        longint y;
        int     n;
        y = 0;
        n = (m + 1) * R - 1;
        for (int k = 0; k < HLEN; k++)
            if (n - 2 - k >= 0) y = y + h[k] * acc[n-2-k];
        return y;
    endfunction

    task start_test;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        out_q.delete();
        cyc_q.delete();
        stim_x.delete();
        stim_v.delete();
    endtask

    // The first sample is driven at the same moment reset is released.
    task run_stim;
        for (int i = 0; i < stim_x.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                rst_n = 1'b1;
                base  = cyc;
            end
            in_valid = stim_v[i];
            in_data  = IN_W'(stim_x[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task test_reset;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd7;
        out_q.delete();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %0d want 0", out_data);
        end
        n_cmp++;
        if (out_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_pulses: got %0d want 0", out_q.size());
        end
        in_valid = 1'b0;
    endtask

    task test_dc(input longint x, input longint e1, input longint e2, input longint e3);
        longint exp_v;
        start_test();
        for (int i = 0; i < 5 * R; i++) begin
            stim_x.push_back(x);
            stim_v.push_back(1'b1);
        end
        run_stim();
        n_cmp++;
        if (out_q.size() != 5) begin
            n_bad++;
            $display("FAIL dc%0d_count: got %0d want 5", x, out_q.size());
        end
        for (int m = 0; m < 5 && m < out_q.size(); m++) begin
            exp_v = (m == 0) ? e1 : (m == 1) ? e2 : e3;
            n_cmp++;
            if (out_q[m] !== exp_v) begin
                n_bad++;
                $display("FAIL dc%0d_out%0d: got %0d want %0d", x, m, out_q[m], exp_v);
            end
            n_cmp++;
            if (cyc_q[m] - base != (m + 1) * R) begin
                n_bad++;
                $display("FAIL dc%0d_lat%0d: got %0d want %0d", x, m, cyc_q[m] - base, (m + 1) * R);
            end
        end
        n_cmp++;
        if ($signed(out_data) !== OUT_W'(e3)) begin
            n_bad++;
            $display("FAIL dc%0d_hold: got %0d want %0d", x, $signed(out_data), e3);
        end
    endtask

    task test_mash;
        start_test();
        for (int i = 0; i < 5 * R; i++) begin
            stim_x.push_back((i % 2 == 0) ? 1 : 0);
            stim_v.push_back(1'b1);
        end
        run_stim();
        n_cmp++;
        if (out_q.size() != 5) begin
            n_bad++;
            $display("FAIL mash_count: got %0d want 5", out_q.size());
        end
        for (int m = 2; m < out_q.size(); m++) begin
            n_cmp++;
            if (out_q[m] !== 64'sd131072) begin
                n_bad++;
                $display("FAIL mash_out%0d: got %0d want 131072", m, out_q[m]);
            end
        end
    endtask

    task test_gap_toggle;
        longint exp_v;
        start_test();
        for (int i = 0; i < 10 * R; i++) begin
            stim_x.push_back(1);
            stim_v.push_back(i % 2 == 0);
        end
        run_stim();
        n_cmp++;
        if (out_q.size() != 5) begin
            n_bad++;
            $display("FAIL gap_count: got %0d want 5", out_q.size());
        end
        for (int m = 0; m < out_q.size(); m++) begin
            exp_v = (m == 0) ? 41664 : (m == 1) ? 216384 : 262144;
            n_cmp++;
            if (out_q[m] !== exp_v) begin
                n_bad++;
                $display("FAIL gap_out%0d: got %0d want %0d", m, out_q[m], exp_v);
            end
            if (m > 0) begin
                n_cmp++;
                if (cyc_q[m] - cyc_q[m-1] != 2 * R) begin
                    n_bad++;
                    $display("FAIL gap_spacing%0d: got %0d want %0d", m, cyc_q[m] - cyc_q[m-1], 2 * R);
                end
            end
        end
    endtask

    task test_random_gaps;
        longint acc[$];
        longint x;
        bit     v;
        longint exp_v;
        start_test();
        while (acc.size() < 6 * R) begin
            x = longint'($urandom_range(15, 0)) - 8;
            v = ($urandom_range(9, 0) < 7);
            stim_x.push_back(x);
            stim_v.push_back(v);
            if (v) acc.push_back(x);
        end
        run_stim();
        n_cmp++;
        if (out_q.size() != 6) begin
            n_bad++;
            $display("FAIL rnd_count: got %0d want 6", out_q.size());
        end
        for (int m = 0; m < out_q.size() && m < 6; m++) begin
            exp_v = ref_out(acc, m);
            n_cmp++;
            if (out_q[m] !== exp_v) begin
                n_bad++;
                $display("FAIL rnd_out%0d: got %0d want %0d", m, out_q[m], exp_v);
            end
        end
    endtask

    task test_reset_mid;
        start_test();
        for (int i = 0; i < 30; i++) begin
            stim_x.push_back(1);
            stim_v.push_back(1'b1);
        end
        run_stim();
        n_cmp++;
        if (out_q.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_partial: got %0d pulses want 0", out_q.size());
        end
        start_test();
        for (int i = 0; i < R; i++) begin
            if (i > 0) @(negedge clk);
            rst_n    = 1'b1;
            in_valid = 1'b1;
            in_data  = IN_W'(1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 22'sd41664) begin
            n_bad++;
            $display("FAIL midrst_first: got valid %b data %0d want 1 / 41664", out_valid, $signed(out_data));
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL async_rst: got valid %b data %0d want 0 / 0", out_valid, out_data);
        end
    endtask

    task test_soak;
        start_test();
        for (int i = 0; i < 20000; i++) begin
            stim_x.push_back(7);
            stim_v.push_back(1'b1);
        end
        run_stim();
        n_cmp++;
        if (out_q.size() != 312) begin
            n_bad++;
            $display("FAIL soak_count: got %0d want 312", out_q.size());
        end
        for (int m = 2; m < out_q.size(); m++) begin
            n_cmp++;
            if (out_q[m] !== 64'sd1835008) begin
                n_bad++;
                $display("FAIL soak_out%0d: got %0d want 1835008", m, out_q[m]);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        base     = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        build_h();
        test_reset();
        test_dc(1, 41664, 216384, 262144);
        test_dc(-8, -333312, -1731072, -2097152);
        test_mash();
        test_gap_toggle();
        test_random_gaps();
        test_reset_mid();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
